mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle CPU datapath; successor to the fixed 32-bit mult/div hooks driven by the control unit.
- One start/done handshake for four ops (signed/unsigned multiply, signed/unsigned divide).
- Result lands in internal HI/LO registers read by the MEMTOREG mux.
- Adds a divide-by-zero flag and back-to-back issue.

Parameters:
- WIDTH, 32, operand width and width of hi/lo (even, >= 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when accepting (IDLE or DONE)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid in hi/lo
- div_zero  out  1  last accepted op was a divide with b==0
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
  - Reset asserted mid-operation aborts the operation. No partial result is written.
- States: IDLE, RUN, FIX, DONE.
- Accept: start==1 at rising edge k while in IDLE or DONE.
  - Latches op, a, b; clears div_zero.
  - start in RUN/FIX is ignored, and operands are not relatched.
- Normal path:
  - Edge k: IDLE/DONE->RUN. Operands converted to magnitudes (signed ops); result sign bits saved. busy=1 from edge k.
  - Edges k+1..k+WIDTH: one iteration per edge. Multiply is shift-add on a 2*WIDTH accumulator. Divide is restoring, one quotient bit per edge. Counter increments 0..WIDTH.
  - Edge k+WIDTH: RUN->FIX once counter hits WIDTH.
  - Edge k+WIDTH+1: FIX->DONE. Sign correction is applied, hi/lo are written, done=1, busy=0.
  - Edge k+WIDTH+2: DONE->IDLE with done=0, unless a new start is accepted.
  - Latency start-edge to done-high: WIDTH+1 cycles (33 at default).
- Divide by zero (op[1]==1, b==0):
  - Edge k goes straight to DONE with done=1, div_zero=1.
  - hi/lo are unchanged.
  - div_zero is held until the next accepted start.
- Arithmetic:
  - MULT: {hi,lo} = signed a × signed b, full 2*WIDTH product.
  - MULTU: same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV of MIN by −1: lo=MIN (wraps), hi=0. No flag is raised.
- Output timing:
  - hi/lo change only on the FIX->DONE edge or on reset, and hold between operations.
  - done is never high for more than one cycle per accepted op.
  - busy and done are never simultaneously high.

Decomposition:
- Package mult_div_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum IDLE/RUN/FIX/DONE.
- One natural sub-module: mult_div_sign_fix, combinational.
  - Inputs: unsigned hi/lo, op, saved operand signs.
  - Outputs: sign-corrected hi/lo.
  - Reused for the operand-magnitude conversion at accept.
- FSM, counter and iteration datapath stay in mult_div_unit.

Test Plan:
- MULT a=FFFFFFFD (−3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; done high exactly 33 cycles after the start edge; busy high for cycles 0..32.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MULT with the same operands -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (−7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. Issue the DIVU with start held during the DIV's DONE cycle; it must be accepted back-to-back.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0. Then DIVU a=5, b=0 -> done one cycle after start, div_zero=1, hi/lo keep previous values; next accepted MULT clears div_zero.
- Start MULT, pulse start with different operands at cycle 5 (ignored), then drop reset low at cycle 10 -> busy/done/hi/lo go 0 immediately without a clock edge. After release, the FSM is in IDLE and a new MULT 3×4 gives lo=12.
- WIDTH=8 instance: MULT 0x80×0x80 -> hi=0x40, lo=0x00; DIV 0x80/0xFF -> lo=0x80, hi=0x00; done 9 cycles after start.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_div_sign_fix.sv
// Combinational sign correction of an unsigned hi/lo pair for signed multiply/divide.
module mult_div_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic [WIDTH-1:0] mag_hi,
  input  logic [WIDTH-1:0] mag_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] prod_neg;

  assign prod_neg = -{mag_hi, mag_lo};

  always_comb begin
    hi = mag_hi;
    lo = mag_lo;
    case (op)
      OP_MULT: begin
        if (neg_a ^ neg_b) begin
          hi = prod_neg[2*WIDTH-1:WIDTH];
          lo = prod_neg[WIDTH-1:0];
        end
      end
      OP_DIV: begin
        // Quotient negative when signs differ; remainder follows the dividend.
        if (neg_a ^ neg_b) lo = -mag_lo;
        if (neg_a)         hi = -mag_hi;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide with start/done handshake,
// HI/LO result registers and a divide-by-zero flag.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state_reg, state_next;
  logic [1:0]         op_reg;
  logic               neg_a_reg, neg_b_reg;
  logic [WIDTH-1:0]   opnd_reg, acc_hi_reg, acc_lo_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               div_zero_reg;

  logic               accept, zero_div, is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b, fix_hi, fix_lo;
  logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;

  assign accept    = ((state_reg == IDLE) || (state_reg == DONE)) && start;
  assign zero_div  = op[1] && (b == '0);
  assign is_signed = ~op[0];

  // Magnitude conversion reuses the divide rule: hi follows a's sign, and
  // neg_b is chosen so that lo is negated exactly when b is negative.
  mult_div_sign_fix #(.WIDTH(WIDTH)) u_operand_mag (
    .op     (is_signed ? OP_DIV : OP_DIVU),
    .neg_a  (is_signed & a[WIDTH-1]),
    .neg_b  (is_signed & (a[WIDTH-1] ^ b[WIDTH-1])),
    .mag_hi (a),
    .mag_lo (b),
    .hi     (abs_a),
    .lo     (abs_b)
  );

  mult_div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .op     (op_reg),
    .neg_a  (neg_a_reg),
    .neg_b  (neg_b_reg),
    .mag_hi (acc_hi_reg),
    .mag_lo (acc_lo_reg),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  // One iteration: shift-add on {acc_hi,acc_lo} or one restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    rem_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_reg};
    step_hi   = acc_hi_reg;
    step_lo   = acc_lo_reg;
    if (op_reg[1]) begin
      step_hi = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
      step_lo = {acc_lo_reg[WIDTH-2:0], ~rem_diff[WIDTH]};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = zero_div ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count_reg == CNT_W'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = zero_div ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg       <= OP_MULT;
      neg_a_reg    <= 1'b0;
      neg_b_reg    <= 1'b0;
      opnd_reg     <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      count_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      op_reg       <= op;
      div_zero_reg <= zero_div;
      count_reg    <= '0;
      neg_a_reg    <= is_signed & a[WIDTH-1];
      neg_b_reg    <= is_signed & b[WIDTH-1];
      opnd_reg     <= abs_b;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= abs_a;
    end else if (state_reg == RUN) begin
      acc_hi_reg <= step_hi;
      acc_lo_reg <= step_lo;
      count_reg  <= count_reg + CNT_W'(1);
    end else if (state_reg == FIX) begin
      hi_reg <= fix_hi;
      lo_reg <= fix_lo;
    end
  end

  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule
